// File: rtl/undet_pkg.sv
// Shared types and constants for the undetermined-function issue stage.
package undet_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_INJ = 2'd1,
    ST_GAP = 2'd2
  } state_e;

  localparam logic [DATA_W-1:0] UKN_IDLE = 8'h00;
endpackage

// File: rtl/undet_fifo.sv
// Synchronous FIFO holding pending injection values; head is read combinationally.
module undet_fifo
  import undet_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]   o_head,
  output logic [CNT_BITS-1:0] o_count
);
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_BITS-1:0] r_count;

  // Storage is left unreset: an entry is only read once count says it is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/undet_issue.sv
// Issue stage: queues injection values and emits en/ukn with a guaranteed
// recompute gap of GAP en=1 cycles after every injection.
module undet_issue
  import undet_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              en,
  output logic [DATA_W-1:0] ukn,
  output logic [CNT_W-1:0]  inj_cnt,
  output logic              busy
);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_gap, w_gap_nxt;
  logic [CNT_W-1:0]    r_inj_cnt, w_inj_cnt_nxt;
  logic                r_en;
  logic [DATA_W-1:0]   r_ukn;

  logic                w_push, w_pop, w_nonempty;
  logic [DATA_W-1:0]   w_head;
  logic [CNT_BITS-1:0] w_count;

  assign in_ready   = (w_count != CNT_BITS'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_nonempty = (w_count != '0);

  undet_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Entry into INJ is decided from the registered count, so a value pushed
  // this cycle can never be popped on the same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_gap_nxt     = r_gap;
    w_inj_cnt_nxt = r_inj_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_nonempty) begin
          w_state_nxt = ST_INJ;
          w_pop       = 1'b1;
        end
      end
      ST_INJ: begin
        w_state_nxt   = ST_GAP;
        w_gap_nxt     = 4'(GAP - 1);
        w_inj_cnt_nxt = r_inj_cnt + CNT_W'(1);
      end
      ST_GAP: begin
        if (r_gap != 4'd0) begin
          w_gap_nxt = r_gap - 4'd1;
        end else if (w_nonempty) begin
          w_state_nxt = ST_INJ;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_gap     <= 4'd0;
      r_inj_cnt <= '0;
      r_en      <= 1'b1;
      r_ukn     <= UKN_IDLE;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_inj_cnt <= w_inj_cnt_nxt;
      r_en      <= !w_pop;
      r_ukn     <= w_pop ? w_head : UKN_IDLE;
    end
  end

  assign en      = r_en;
  assign ukn     = r_ukn;
  assign inj_cnt = r_inj_cnt;
  assign busy    = w_nonempty || (r_state != ST_RUN);
endmodule

// File: tb/tb_undet_issue.sv
// Randomised and directed checks of undet_issue against a cycle-level
// schedule model (queue of pushed values with their push cycle).
module tb_undet_issue;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready, en, busy;
  logic [7:0]       ukn;
  logic [CNT_W-1:0] inj_cnt;

  undet_issue #(.DEPTH(DEPTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .ukn(ukn), .inj_cnt(inj_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: values waiting to be injected, tagged with their push cycle.
  int q_data[$];
  int q_t[$];
  int last_inj  = -1000;
  int inj_total = 0;
  bit accepted  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // An injection appears at cycle t when the head was pushed by t-2 and at
  // least GAP en=1 cycles have passed since the previous injection.
  task automatic step();
    bit inj, bsy, rdy;
    int eu, cnt;
    inj = (q_data.size() > 0) && (q_t[0] <= cyc - 2) && (cyc >= last_inj + GAP + 1);
    eu  = 0;
    if (inj) begin
      eu = q_data.pop_front();
      void'(q_t.pop_front());
    end
    cnt = q_data.size();
    rdy = (cnt != DEPTH);
    bsy = (cnt != 0) || inj || (cyc <= last_inj + GAP);
    chk("en", 32'(en), 32'(!inj));
    chk("ukn", 32'(ukn), 32'(eu));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(bsy));
    chk("inj_cnt", 32'(inj_cnt), 32'(inj_total % 256));
    if (inj) begin
      last_inj = cyc;
      inj_total++;
    end
    accepted = 1'b0;
    if (!rst) begin
      q_data.delete();
      q_t.delete();
      last_inj  = -1000;
      inj_total = 0;
    end else if (in_valid && rdy) begin
      q_data.push_back(int'(in_data));
      q_t.push_back(cyc);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int base, first_full, v, iter;
    bit wrapped;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset.
    repeat (10) step();

    // Single push.
    in_valid = 1'b1; in_data = 8'hA5;
    base = cyc;
    step();
    in_valid = 1'b0;
    step();
    chk("single_inj_en", 32'(en), 32'd0);
    chk("single_inj_ukn", 32'(ukn), 32'hA5);
    repeat (8) step();

    // Back-to-back pushes.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1));
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();

    // Held source of 01..0A fills the FIFO.
    base = cyc; first_full = -1; v = 1; iter = 0;
    while (v <= 10 && iter < 100) begin
      in_valid = 1'b1; in_data = 8'(v);
      if (!in_ready && first_full < 0) first_full = cyc - base;
      step();
      if (accepted) v++;
      iter++;
    end
    in_valid = 1'b0;
    chk("first_full_cycle", 32'(first_full), 32'd6);
    repeat (30) step();

    // Reset during the second injection with two entries still queued.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    chk("rst_during_inj_en", 32'(en), 32'd0);
    step();
    rst = 1'b1; in_valid = 1'b0;
    chk("after_rst_inj_cnt", 32'(inj_cnt), 32'd0);
    chk("after_rst_busy", 32'(busy), 32'd0);
    repeat (12) step();

    // Random traffic; source holds its value until accepted.
    accepted = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (accepted || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (20) step();

    // Saturating traffic until the injection counter wraps.
    wrapped = 1'b0; iter = 0; accepted = 1'b1;
    while (!wrapped && iter < 3000) begin
      if (accepted) in_data = 8'($urandom);
      in_valid = 1'b1;
      step();
      if (inj_total == 256) begin
        wrapped = 1'b1;
        chk("wrap_inj_cnt", 32'(inj_cnt), 32'd0);
      end
      iter++;
    end
    if (!wrapped) chk("wrap_timeout", 32'(iter), 32'd0);
    in_valid = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/undet_issue.md
Name: undet_issue

Overview:
- Upstream issue stage for the undetermined-function datapath stage (`undetfunc`).
- Buffers externally supplied 8-bit injection values in a small FIFO and generates the `en`/`ukn` pair consumed downstream.
- `en=0` means "inject `ukn` this cycle" to the downstream stage.
- Enforces a minimum spacing of `en=1` cycles after every injection. This lets the downstream registers that are undefined after an injection (`r0` takes X when `en=0`) be recomputed before the next injection.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- GAP, 2, minimum number of `en=1` cycles between consecutive injections; range 1..15.
- CNT_W, 16, width of the injection counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of `clk`.
- in_valid  in  1  injection value offered.
- in_data  in  8  injection value.
- in_ready  out  1  FIFO can accept; = (count != DEPTH), from registered count.
- en  out  1  registered; 0 only in the INJ state.
- ukn  out  8  registered; FIFO head value during INJ, 8'h00 otherwise (never X).
- inj_cnt  out  CNT_W  number of injections since reset; wraps to 0.
- busy  out  1  = (count != 0) || (state != RUN).

Behaviour:
- Reset (`rst==0` at an edge):
  - state=RUN, FIFO pointers and count = 0.
  - en=1, ukn=8'h00, inj_cnt=0, gap_cnt=0.
  - Reset takes priority over every other event, including mid-injection and a simultaneous push. FIFO contents are discarded.
- Push: `in_valid && in_ready` at an edge writes `in_data` at the write pointer. Pointers wrap modulo DEPTH.
- No bypass: a value pushed into an empty FIFO at cycle t appears on `ukn` with `en=0` no earlier than cycle t+2.
- Pop: occurs on the edge that enters INJ. The head value is latched into the `ukn` register on that same edge.
- Full plus simultaneous pop: `in_ready` is already 0, so no push happens that cycle. The count decrements.
- Empty plus simultaneous push: count increments. There is no pop, because the entry decision uses the registered count.
- State RUN (en=1, ukn=0): if count != 0, go to INJ and pop; otherwise stay in RUN.
- State INJ (en=0, ukn=head value), exactly one cycle:
  - inj_cnt += 1 (wraps).
  - gap_cnt = GAP-1.
  - Go to GAP.
- State GAP (en=1, ukn=0):
  - if gap_cnt != 0: decrement gap_cnt and stay in GAP.
  - if gap_cnt == 0 and count != 0: go to INJ and pop.
  - if gap_cnt == 0 and count == 0: go to RUN.
- Invariants:
  - Injections are separated by exactly GAP `en=1` cycles when the FIFO is never empty.
  - Two consecutive `en=0` cycles never occur.
  - `ukn` values leave in push order, with no loss or duplication.
- `in_valid` while `in_ready=0`: ignored, no state change. The source must hold its value.

Decomposition:
- Package `undet_pkg`:
  - DATA_W=8.
  - State enum {RUN, INJ, GAP}, 2 bits.
  - Constant UKN_IDLE=8'h00.
- Sub-module `undet_fifo`:
  - Synchronous FIFO, parameter DEPTH.
  - Ports: push/pop/data in/head out/count.
  - Same `clk`/`rst` convention as this block.
- FSM, gap counter, injection counter and output registers live in `undet_issue`.

Test Plan:
- Reset release with in_valid=0 for 10 cycles -> en=1, ukn=00, inj_cnt=0, busy=0, in_ready=1 every cycle.
- Single push 8'hA5 at cycle 0 -> en=0 and ukn=A5 at cycle 2 only; en=1 cycles 3+; inj_cnt=1 from cycle 3; busy=0 from cycle 5.
- Pushes 11,22,33 at cycles 0,1,2, GAP=2 -> en=0 at cycles 2,5,8 with ukn=11,22,33; en=1 with ukn=00 elsewhere; inj_cnt=3.
- in_valid held 10 cycles with data 01..0A, DEPTH=4 -> in_ready first deasserts at cycle 6 (count=4); each full cycle is followed by a pop; ukn sequence exactly 01..0A, every injection spaced by 2 en=1 cycles.
- rst=0 asserted during an INJ cycle with 2 entries queued -> next cycle en=1, ukn=00, inj_cnt=0, busy=0; no stale value is ever injected afterwards.
- Force inj_cnt to FFFF and inject once -> inj_cnt=0000, no other side effects.
